// File: rtl/dot_product_stream_pkg.sv
// Shared types and helpers for the streaming dot-product engine.
package dot_product_stream_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    localparam int unsigned SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] val;
        logic                    sat;
    } sat_res_t;

    function automatic int unsigned prod_w(input int unsigned pix_w, input int unsigned wgt_w);
        return pix_w + wgt_w + 1;
    endfunction

    function automatic int unsigned tree_depth(input int unsigned lanes);
        return $clog2(lanes);
    endfunction

    // Clip a signed value into the range of an out_w-bit two's complement number.
    function automatic sat_res_t sat_signed(input logic signed [SAT_W-1:0] val,
                                            input int unsigned out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                r;
        hi    = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
        lo    = ~hi;
        r.val = val;
        r.sat = 1'b0;
        if (val > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (val < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_product_stream_if.sv
// Beat input and result output handshake bundle of the dot-product engine.
interface dot_product_stream_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned PIX_W = 10,
    parameter int unsigned WGT_W = 19,
    parameter int unsigned OUT_W = 26
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic [LANES*PIX_W-1:0]   in_pixel;
    logic [LANES*WGT_W-1:0]   in_weight;
    logic [WGT_W-1:0]         in_bias;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic                     out_sat;
    logic                     out_overrun;

    modport master (
        output in_valid, in_last, in_pixel, in_weight, in_bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_overrun
    );

    modport slave (
        input  in_valid, in_last, in_pixel, in_weight, in_bias, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_overrun
    );
endinterface

// File: rtl/dot_product_stream_tree.sv
// Registered binary adder tree; one register level per tree level, tags pipelined alongside.
module dp_adder_tree #(
    parameter int unsigned LANES = 4,
    parameter int unsigned ACC_W = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [LANES*ACC_W-1:0]   in_data,
    output logic                     out_valid,
    output logic                     out_first,
    output logic                     out_last,
    output logic signed [ACC_W-1:0]  out_sum
);
    localparam int unsigned TD    = $clog2(LANES);
    localparam int unsigned NODES = LANES - 1;

    logic signed [ACC_W-1:0] node_q [NODES];
    logic signed [ACC_W-1:0] heap   [2*LANES-1];
    logic [TD-1:0]           vld_q;
    logic [TD-1:0]           first_q;
    logic [TD-1:0]           last_q;

    // Heap view: internal nodes are registers, leaves are the lane inputs.
    always_comb begin
        heap = '{default: '0};
        for (int i = 0; i < NODES; i++) begin
            heap[i] = node_q[i];
        end
        for (int k = 0; k < LANES; k++) begin
            heap[NODES+k] = $signed(in_data[k*ACC_W +: ACC_W]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NODES; i++) begin
            node_q[i] <= heap[2*i+1] + heap[2*i+2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            vld_q[0]   <= in_valid;
            first_q[0] <= in_first;
            last_q[0]  <= in_last;
            for (int i = 1; i < TD; i++) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[TD-1];
    assign out_first = first_q[TD-1];
    assign out_last  = last_q[TD-1];
    assign out_sum   = node_q[0];

endmodule

// File: rtl/dot_product_stream.sv
// Streaming fixed-point dot product: multiply, tree-reduce, accumulate over beats,
// add bias and saturate; one vector in flight, result held until consumed.
module dot_product_stream
    import dot_product_stream_pkg::*;
#(
    parameter int unsigned LANES      = 4,
    parameter int unsigned PIX_W      = 10,
    parameter int unsigned WGT_W      = 19,
    parameter int unsigned ACC_W      = 40,
    parameter int unsigned OUT_W      = 26,
    parameter int unsigned FRAC_SHIFT = 0,
    parameter int unsigned MAX_BEATS  = 256
) (
    input  logic                 clk,
    input  logic                 GlobalReset,
    dot_product_stream_if.slave  bus
);
    localparam int unsigned PROD_W = prod_w(PIX_W, WGT_W);
    localparam int unsigned SUM_W  = ACC_W + 1;
    // One spare count above MAX_BEATS so the overrun value always fits.
    localparam int unsigned CNT_W  = $clog2(MAX_BEATS + 2);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

    state_t                   state;
    logic [CNT_W-1:0]         beat_cnt;
    logic signed [WGT_W-1:0]  bias_q;
    logic                     accept;

    logic signed [PROD_W-1:0] prod [LANES];
    logic [LANES*ACC_W-1:0]   prod_ext;

    logic [LANES*ACC_W-1:0]   p1_data;
    logic                     p1_v, p1_first, p1_last;

    logic                     tree_v, tree_first, tree_last;
    logic signed [ACC_W-1:0]  tree_sum;

    logic signed [ACC_W-1:0]  acc;
    logic                     acc_v, acc_last;

    logic signed [SUM_W-1:0]  final_sum;
    sat_res_t                 sat_res;
    logic                     fin_v, fin_sat;
    logic [OUT_W-1:0]         fin_data;

    assign accept = bus.in_valid && bus.in_ready;

    // Signed weight times zero-extended pixel, scaled, widened to the accumulator.
    always_comb begin
        prod     = '{default: '0};
        prod_ext = '0;
        for (int k = 0; k < LANES; k++) begin
            prod[k] = PROD_W'($signed(bus.in_weight[k*WGT_W +: WGT_W]))
                    * PROD_W'($signed({1'b0, bus.in_pixel[k*PIX_W +: PIX_W]}));
            prod_ext[k*ACC_W +: ACC_W] = ACC_W'(prod[k] >>> FRAC_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            p1_v     <= 1'b0;
            p1_first <= 1'b0;
            p1_last  <= 1'b0;
        end else begin
            p1_v <= accept;
            if (accept) begin
                p1_data  <= prod_ext;
                p1_first <= (state == IDLE);
                p1_last  <= bus.in_last;
            end
        end
    end

    dp_adder_tree #(
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) u_tree (
        .clk       (clk),
        .rst       (GlobalReset),
        .in_valid  (p1_v),
        .in_first  (p1_first),
        .in_last   (p1_last),
        .in_data   (p1_data),
        .out_valid (tree_v),
        .out_first (tree_first),
        .out_last  (tree_last),
        .out_sum   (tree_sum)
    );

    // First beat of a vector loads the accumulator instead of adding.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            acc      <= '0;
            acc_v    <= 1'b0;
            acc_last <= 1'b0;
        end else begin
            acc_v    <= tree_v;
            acc_last <= tree_last;
            if (tree_v) begin
                acc <= tree_first ? tree_sum : acc + tree_sum;
            end
        end
    end

    always_comb begin
        final_sum = SUM_W'(acc) + SUM_W'(bias_q);
        sat_res   = sat_signed(SAT_W'(final_sum), OUT_W);
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            fin_v    <= 1'b0;
            fin_data <= '0;
            fin_sat  <= 1'b0;
        end else begin
            fin_v <= acc_v && acc_last;
            if (acc_v && acc_last) begin
                fin_data <= OUT_W'(sat_res.val);
                fin_sat  <= sat_res.sat;
            end
        end
    end

    // Control FSM: owns the handshake outputs, beat counter and bias capture.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state           <= IDLE;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_sat     <= 1'b0;
            bus.out_overrun <= 1'b0;
            beat_cnt        <= '0;
            bias_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bias_q   <= $signed(bus.in_bias);
                        beat_cnt <= CNT_W'(1);
                        if (bus.in_last) begin
                            state        <= DRAIN;
                            bus.in_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (beat_cnt != CNT_SAT) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                        if (bus.in_last) begin
                            state        <= DRAIN;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (fin_v) begin
                        state           <= HOLD;
                        bus.out_valid   <= 1'b1;
                        bus.out_data    <= fin_data;
                        bus.out_sat     <= fin_sat;
                        bus.out_overrun <= (beat_cnt > CNT_LIM);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state           <= IDLE;
                        bus.out_valid   <= 1'b0;
                        bus.out_sat     <= 1'b0;
                        bus.out_overrun <= 1'b0;
                        bus.in_ready    <= 1'b1;
                        beat_cnt        <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_stream.sv
// Directed bench: two DUTs (MAX_BEATS 256 and 4) driven with identical beat streams.
module tb_dot_product_stream;
    localparam int unsigned LANES = 4;
    localparam int unsigned PIX_W = 10;
    localparam int unsigned WGT_W = 19;
    localparam int unsigned OUT_W = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   drv_valid, drv_last, drv_ordy;
    logic [LANES*PIX_W-1:0] drv_pix;
    logic [LANES*WGT_W-1:0] drv_wgt;
    logic [WGT_W-1:0]       drv_bias;

    dot_product_stream_if #(.LANES(LANES), .PIX_W(PIX_W), .WGT_W(WGT_W), .OUT_W(OUT_W)) bus_a ();
    dot_product_stream_if #(.LANES(LANES), .PIX_W(PIX_W), .WGT_W(WGT_W), .OUT_W(OUT_W)) bus_b ();

    assign bus_a.in_valid  = drv_valid;
    assign bus_a.in_last   = drv_last;
    assign bus_a.in_pixel  = drv_pix;
    assign bus_a.in_weight = drv_wgt;
    assign bus_a.in_bias   = drv_bias;
    assign bus_a.out_ready = drv_ordy;
    assign bus_b.in_valid  = drv_valid;
    assign bus_b.in_last   = drv_last;
    assign bus_b.in_pixel  = drv_pix;
    assign bus_b.in_weight = drv_wgt;
    assign bus_b.in_bias   = drv_bias;
    assign bus_b.out_ready = drv_ordy;

    dot_product_stream #(.LANES(LANES), .PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(40),
                         .OUT_W(OUT_W), .FRAC_SHIFT(0), .MAX_BEATS(256))
        dut_a (.clk(clk), .GlobalReset(rst), .bus(bus_a));

    dot_product_stream #(.LANES(LANES), .PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(40),
                         .OUT_W(OUT_W), .FRAC_SHIFT(0), .MAX_BEATS(4))
        dut_b (.clk(clk), .GlobalReset(rst), .bus(bus_b));

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string  name;
        int     beats;
        int     pix;
        int     wbase;
        int     wstep;
        int     bias;
        bit     gaps;
        longint exp_data;
        bit     exp_sat;
        bit     exp_ovr_b;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Sends n_send beats of a vector of 'beats' beats; weight = wbase + wstep*element index.
    task automatic send_vector(input int beats, input int n_send, input int pix,
                               input int wbase, input int wstep, input int bias, input bit gaps);
        for (int b = 0; b < n_send; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    drv_valid = 1'b0;
                    drv_pix   = (LANES*PIX_W)'({$urandom, $urandom});
                    drv_wgt   = (LANES*WGT_W)'({$urandom, $urandom, $urandom});
                    @(posedge clk); #1;
                end
            end
            for (int k = 0; k < LANES; k++) begin
                drv_pix[k*PIX_W +: PIX_W] = PIX_W'(pix);
                drv_wgt[k*WGT_W +: WGT_W] = WGT_W'(wbase + wstep * (b * int'(LANES) + k));
            end
            drv_bias  = WGT_W'(bias);
            drv_last  = (b == beats - 1);
            drv_valid = 1'b1;
            begin
                int t = 0;
                while (!bus_a.in_ready && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
            end
            if (!bus_a.in_ready) begin
                check("in_ready_timeout", 0, 1);
                drv_valid = 1'b0;
                drv_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        drv_bias  = WGT_W'(12345);
    endtask

    task automatic wait_result(input string name, input longint exp_data, input bit exp_sat,
                               input bit exp_ovr_b);
        int lat = 0;
        while (!bus_a.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_valid"},   longint'(bus_a.out_valid), 1);
        check({name, "_latency"}, longint'(lat), 5);
        check({name, "_data"},    longint'($signed(bus_a.out_data)), exp_data);
        check({name, "_sat"},     longint'(bus_a.out_sat), longint'(exp_sat));
        check({name, "_ovr_a"},   longint'(bus_a.out_overrun), 0);
        check({name, "_data_b"},  longint'($signed(bus_b.out_data)), exp_data);
        check({name, "_sat_b"},   longint'(bus_b.out_sat), longint'(exp_sat));
        check({name, "_ovr_b"},   longint'(bus_b.out_overrun), longint'(exp_ovr_b));
    endtask

    task automatic handshake(input string name);
        drv_ordy = 1'b1;
        @(posedge clk); #1;
        drv_ordy = 1'b0;
        check({name, "_hs_valid_low"}, longint'(bus_a.out_valid), 0);
        check({name, "_hs_ready_high"}, longint'(bus_a.in_ready), 1);
        check({name, "_hs_ovr_b_clear"}, longint'(bus_b.out_overrun), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"two_beat",   2,    1,       1, 1,      10, 1'b0,       46, 1'b0, 1'b0};
        vecs[1] = '{"neg_sat",    1, 1023, -262144, 0,       0, 1'b0, -33554432, 1'b1, 1'b0};
        vecs[2] = '{"long_gaps",196,    1,       1, 0,      -5, 1'b1,      779, 1'b0, 1'b1};
        vecs[3] = '{"pos_sat",    1, 1023,  262143, 0,       0, 1'b0,  33554431, 1'b1, 1'b0};
        vecs[4] = '{"edge_max",   1, 1023,    8200, 0,      31, 1'b0,  33554431, 1'b0, 1'b0};
        vecs[5] = '{"edge_over",  1, 1023,    8200, 0,      32, 1'b0,  33554431, 1'b1, 1'b0};
        vecs[6] = '{"edge_min",   1, 1023,   -8200, 0,     -32, 1'b0, -33554432, 1'b0, 1'b0};
        vecs[7] = '{"edge_under", 1, 1023,   -8200, 0,     -33, 1'b0, -33554432, 1'b1, 1'b0};
        vecs[8] = '{"mixed_neg",  2,    5,      -3, 0,       7, 1'b0,     -113, 1'b0, 1'b0};
        vecs[9] = '{"bias_only",  3,    0,     100, 7, -262144, 1'b1,  -262144, 1'b0, 1'b0};

        drv_valid = 1'b0;
        drv_last  = 1'b0;
        drv_ordy  = 1'b0;
        drv_pix   = '0;
        drv_wgt   = '0;
        drv_bias  = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_in_ready",    longint'(bus_a.in_ready), 1);
        check("rst_out_valid",   longint'(bus_a.out_valid), 0);
        check("rst_out_data",    longint'(bus_a.out_data), 0);
        check("rst_out_sat",     longint'(bus_a.out_sat), 0);
        check("rst_out_overrun", longint'(bus_a.out_overrun), 0);
        check("rst_in_ready_b",  longint'(bus_b.in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            send_vector(vecs[i].beats, vecs[i].beats, vecs[i].pix, vecs[i].wbase,
                        vecs[i].wstep, vecs[i].bias, vecs[i].gaps);
            wait_result(vecs[i].name, vecs[i].exp_data, vecs[i].exp_sat, vecs[i].exp_ovr_b);
            handshake(vecs[i].name);
        end

        // Backpressure: result must hold while out_ready stays low.
        send_vector(2, 2, 1, 1, 1, 10, 1'b0);
        wait_result("bp", 46, 1'b0, 1'b0);
        begin
            bit stable = 1'b1;
            bit blocked = 1'b1;
            repeat (10) begin
                @(posedge clk); #1;
                if (!bus_a.out_valid || $signed(bus_a.out_data) != 46 || bus_a.out_sat) stable = 1'b0;
                if (bus_a.in_ready) blocked = 1'b0;
            end
            check("bp_out_stable", longint'(stable), 1);
            check("bp_in_ready_low", longint'(blocked), 1);
        end
        handshake("bp");
        send_vector(1, 1, 2, 3, 0, 0, 1'b0);
        wait_result("bp_next", 24, 1'b0, 1'b0);
        handshake("bp_next");

        // Reset in the middle of a vector discards it.
        send_vector(5, 3, 7, 11, 0, 100, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready",  longint'(bus_a.in_ready), 1);
        check("midrst_out_valid", longint'(bus_a.out_valid), 0);
        check("midrst_out_data",  longint'(bus_a.out_data), 0);
        check("midrst_out_sat",   longint'(bus_a.out_sat), 0);
        check("midrst_overrun",   longint'(bus_a.out_overrun), 0);
        begin
            bit quiet = 1'b1;
            repeat (8) begin
                @(posedge clk); #1;
                if (bus_a.out_valid || bus_b.out_valid) quiet = 1'b0;
            end
            check("midrst_no_residue_valid", longint'(quiet), 1);
        end
        send_vector(2, 2, 1, 1, 1, 10, 1'b0);
        wait_result("after_rst", 46, 1'b0, 1'b0);
        handshake("after_rst");

        // Overrun on the MAX_BEATS=4 instance, then cleared for the next vector.
        send_vector(6, 6, 1, 1, 0, 0, 1'b0);
        wait_result("overrun", 24, 1'b0, 1'b1);
        handshake("overrun");
        send_vector(1, 1, 1, 1, 0, 0, 1'b0);
        wait_result("post_overrun", 4, 1'b0, 1'b0);
        handshake("post_overrun");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
